// File: rtl/instr_buffer.sv
// IFU-to-decode instruction buffer: compacts enabled fetch lanes into a circular
// FIFO and offers up to DEQ_WIDTH in-order instructions per cycle.
module instr_buffer #(
    parameter int ENQ_WIDTH  = 16,
    parameter int DEQ_WIDTH  = 4,
    parameter int DEPTH      = 32,
    parameter int VADDR_BITS = 39,
    parameter int INST_BITS  = 32,
    parameter int PD_BITS    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            enq_valid,
    output logic                            enq_ready,
    input  logic [ENQ_WIDTH-1:0]            enq_enable,
    input  logic [ENQ_WIDTH*VADDR_BITS-1:0] enq_pc,
    input  logic [ENQ_WIDTH*INST_BITS-1:0]  enq_instr,
    input  logic [ENQ_WIDTH*PD_BITS-1:0]    enq_pd,
    output logic [DEQ_WIDTH-1:0]            deq_valid,
    input  logic                            deq_ready,
    output logic [DEQ_WIDTH*VADDR_BITS-1:0] deq_pc,
    output logic [DEQ_WIDTH*INST_BITS-1:0]  deq_instr,
    output logic [DEQ_WIDTH*PD_BITS-1:0]    deq_pd,
    output logic [$clog2(DEPTH):0]          count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [VADDR_BITS-1:0] pc_mem    [DEPTH];
    logic [INST_BITS-1:0]  instr_mem [DEPTH];
    logic [PD_BITS-1:0]    pd_mem    [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] n_enq, n_avail, n_deq;
    logic [CNT_W-1:0] enq_off [ENQ_WIDTH];
    logic [PTR_W-1:0] wr_idx  [ENQ_WIDTH];
    logic             enq_fire, deq_fire;

    assign count = count_q;

    // Conservative: a same-cycle dequeue is not credited toward free space.
    assign enq_ready = (CNT_W'(DEPTH) - count_q >= CNT_W'(ENQ_WIDTH)) && !rst;
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_ready && !flush;

    // Exclusive prefix popcount gives each enabled lane its slot past the tail.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            enq_off[i] = n_enq;
            wr_idx[i]  = tail + PTR_W'(n_enq);
            n_enq      = n_enq + CNT_W'(enq_enable[i]);
        end
    end

    assign n_avail = (count_q < CNT_W'(DEQ_WIDTH)) ? count_q : CNT_W'(DEQ_WIDTH);
    assign n_deq   = deq_fire ? n_avail : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + PTR_W'(n_enq);
            head    <= head + PTR_W'(n_deq);
            count_q <= count_q + (enq_fire ? n_enq : '0) - n_deq;
        end
    end

    // Storage has no reset; validity is tracked solely by head/count.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (enq_enable[i]) begin
                    pc_mem[wr_idx[i]]    <= enq_pc[i*VADDR_BITS +: VADDR_BITS];
                    instr_mem[wr_idx[i]] <= enq_instr[i*INST_BITS +: INST_BITS];
                    pd_mem[wr_idx[i]]    <= enq_pd[i*PD_BITS +: PD_BITS];
                end
            end
        end
    end

    for (genvar j = 0; j < DEQ_WIDTH; j++) begin : g_deq
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx       = head + PTR_W'(j);
        assign deq_valid[j] = CNT_W'(j) < n_avail;
        assign deq_pc[j*VADDR_BITS +: VADDR_BITS] = pc_mem[rd_idx];
        assign deq_instr[j*INST_BITS +: INST_BITS] = instr_mem[rd_idx];
        assign deq_pd[j*PD_BITS +: PD_BITS]        = pd_mem[rd_idx];
    end
endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
Receiving end of the IFU-to-IBuffer interface: the IBuffer receiver for the IFU's `to_ibuffer_*` outputs. Accepts one fetch packet per cycle of up to ENQ_WIDTH predecoded instructions, qualified by a per-lane enable mask. It compacts enabled lanes into a circular FIFO and presents up to DEQ_WIDTH in-order instructions per cycle to decode. A flush (backend redirect or BPU flush) empties it in one cycle.

Parameters:
ENQ_WIDTH, 16, lanes per fetch packet (equals ifu_pkg::PredictWidth).
DEQ_WIDTH, 4, instructions offered to decode per cycle.
DEPTH, 32, FIFO entries; power of two; DEPTH >= ENQ_WIDTH.
VADDR_BITS, 39, PC width (equals ifu_pkg::VAddrBits).
INST_BITS, 32, instruction width.
PD_BITS, 8, opaque predecode-info width; stored and forwarded unchanged.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all contents (redirect).
enq_valid  in  1  fetch packet valid (IFU to_ibuffer_valid).
enq_ready  out  1  buffer can take a full packet (IFU ibuffer_ready).
enq_enable  in  ENQ_WIDTH  per-lane enable; bit i set means lane i is kept.
enq_pc  in  ENQ_WIDTH*VADDR_BITS  lane PCs, lane i at bits [i*VADDR_BITS +: VADDR_BITS].
enq_instr  in  ENQ_WIDTH*INST_BITS  lane instructions, same packing.
enq_pd  in  ENQ_WIDTH*PD_BITS  lane predecode info, same packing.
deq_valid  out  DEQ_WIDTH  lane j valid; always a thermometer code, lane 0 first.
deq_ready  in  1  decode accepts all currently valid deq lanes.
deq_pc  out  DEQ_WIDTH*VADDR_BITS  dequeue PCs.
deq_instr  out  DEQ_WIDTH*INST_BITS  dequeue instructions.
deq_pd  out  DEQ_WIDTH*PD_BITS  dequeue predecode info.
count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- State: storage[DEPTH], head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count register.
- Reset (rst=1 at posedge): head=tail=count=0.
  - While rst is high, enq_ready=0; deq_valid=0 follows from count=0.
  - Storage contents are not reset; deq_* data lanes are don't-care when their valid bit is 0.
- enq_ready = (DEPTH - count >= ENQ_WIDTH) && !rst.
  - Purely combinational from the registered count.
  - Does not credit a same-cycle dequeue; it is conservative by design.
- Enqueue fires when enq_valid && enq_ready && !flush.
  - Let n_enq = popcount(enq_enable).
  - The k-th set bit of enq_enable, ascending lane order, is written to storage[(tail+k) mod DEPTH].
  - tail advances by n_enq.
  - An all-zero mask is a legal handshake that writes nothing.
- Enqueue when enq_valid && !enq_ready: no write. IFU holds the packet; the buffer takes no action.
- Dequeue lanes: n_avail = min(count, DEQ_WIDTH).
  - deq_valid[j] = (j < n_avail).
  - Lane j shows storage[(head+j) mod DEPTH], combinational from the current head.
- Dequeue fires when deq_ready && !flush: head advances by n_avail and count decreases by n_avail.
  - deq_ready while count=0 has no effect.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq.
  - No read-during-write hazard: enqueued entries land beyond the old tail and are never in the current deq window.
- Latency: an entry enqueued at edge N appears on deq_* in the cycle after edge N, when it is at the head.
  - There is no same-cycle bypass.
- Flush: at the next posedge, head=tail=count=0.
  - Same-cycle enqueue and dequeue are both discarded.
  - flush has priority over everything except rst.
- Wrap-around: write and read indices use modulo DEPTH. A packet or a deq window may straddle entry DEPTH-1 to entry 0.
- Invariants (assert in the bench):
  - count <= DEPTH.
  - tail == (head + count) mod DEPTH.
  - deq_valid is a thermometer code.
- Arithmetic: n_enq and n_deq are computed at count width; no overflow, guaranteed by the enq_ready rule.

Test Plan:
- Reset/basic: after rst, one packet with enq_enable=16'h000F, PCs 0x80000000 +4i -> next cycle count=4, deq_valid=4'b1111, deq_pc lane 0..3 = 0x80000000/04/08/0C; deq_ready=1 -> count=0.
- Sparse compaction: enq_enable=16'b0000_0000_1010_0101 (lanes 0,2,5,7) -> count=4, deq_instr lanes 0..3 equal the lane 0,2,5,7 instructions in order.
- Backpressure/full: deq_ready=0, three full packets (16 lanes each) -> first two accepted, count=32, enq_ready=0 and third not written; deq_ready=1 for one cycle -> count=28 but enq_ready stays 0 until count<=16.
- Partial dequeue and wrap: fill to count=3 near head=30 -> deq_valid=4'b0111, lanes read storage[30],[31],[0]; concurrent enqueue of 16 lanes with deq_ready=1 -> count=3+16-3=16.
- Flush priority: count=10, flush=1 with enq_valid=1 (mask 16'hFFFF) and deq_ready=1 -> next cycle count=0, deq_valid=0, enq_ready=1; a packet the following cycle lands at index 0.
- Reset mid-operation: count=20, assert rst with enq_valid=1 -> enq_ready=0 during rst; after release count=0, no stale deq_valid.
